// File: rtl/uart_alici.sv
// 8N1 UART receiver: two-flop RX synchroniser, mid-bit sampling FSM, stop-bit check
// and a one-entry valid/ready output register with overrun and framing-error pulses.
//
// state | meaning
// BOSTA | idle, waiting for rx_s to fall
// BASLA | half a bit period into the start bit, confirming it is still low
// AL    | sampling the 8 data bits at mid-period, LSB first
// DUR   | sampling the stop bit
// BEKLE | after a framing error, waiting for the line to return high
module uart_alici #(
`ifdef FAST_UART
    parameter logic [31:0] UART_SAAT = 32'd16
`else
    parameter logic [31:0] UART_SAAT = 32'd2083
`endif
) (
    input  logic       clk_g,
    input  logic       rst_g,
    input  logic       RX,
    output logic [7:0] al_veri,
    output logic       al_gecerli,
    input  logic       al_hazir,
    output logic       cerceve_hata,
    output logic       tasma,
    output logic       mesgul
);

    localparam logic [31:0] YARIM = UART_SAAT / 32'd2;

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        BASLA = 3'd1,
        AL    = 3'd2,
        DUR   = 3'd3,
        BEKLE = 3'd4
    } durum_t;

    durum_t      durum_q, durum_d;
    logic [31:0] sayac_q, sayac_d;
    logic [2:0]  indeks_q, indeks_d;
    logic [7:0]  kaydirma_q, kaydirma_d;
    logic [7:0]  veri_q, veri_d;
    logic        gecerli_q, gecerli_d;
    logic        hata_q, hata_d;
    logic        tasma_q, tasma_d;
    logic        rx_m_q, rx_m_d;
    logic        rx_s_q, rx_s_d;
    logic        teslim;

    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            durum_q    <= BOSTA;
            sayac_q    <= 32'd0;
            indeks_q   <= 3'd0;
            kaydirma_q <= 8'd0;
            veri_q     <= 8'd0;
            gecerli_q  <= 1'b0;
            hata_q     <= 1'b0;
            tasma_q    <= 1'b0;
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
        end else begin
            durum_q    <= durum_d;
            sayac_q    <= sayac_d;
            indeks_q   <= indeks_d;
            kaydirma_q <= kaydirma_d;
            veri_q     <= veri_d;
            gecerli_q  <= gecerli_d;
            hata_q     <= hata_d;
            tasma_q    <= tasma_d;
            rx_m_q     <= rx_m_d;
            rx_s_q     <= rx_s_d;
        end
    end

    always_comb begin
        durum_d    = durum_q;
        sayac_d    = sayac_q;
        indeks_d   = indeks_q;
        kaydirma_d = kaydirma_q;
        veri_d     = veri_q;
        gecerli_d  = gecerli_q;
        hata_d     = 1'b0;
        tasma_d    = 1'b0;
        rx_m_d     = RX;
        rx_s_d     = rx_m_q;
        teslim     = 1'b0;

        if (gecerli_q && al_hazir) gecerli_d = 1'b0;

        case (durum_q)
            BOSTA: begin
                sayac_d = 32'd0;
                if (!rx_s_q) durum_d = BASLA;
            end
            BASLA: begin
                if (sayac_q == YARIM) begin
                    sayac_d  = 32'd0;
                    indeks_d = 3'd0;
                    durum_d  = rx_s_q ? BOSTA : AL;
                end else begin
                    sayac_d = sayac_q + 32'd1;
                end
            end
            AL: begin
                if (sayac_q == UART_SAAT) begin
                    sayac_d              = 32'd0;
                    kaydirma_d[indeks_q] = rx_s_q;
                    if (indeks_q == 3'd7) durum_d = DUR;
                    else indeks_d = indeks_q + 3'd1;
                end else begin
                    sayac_d = sayac_q + 32'd1;
                end
            end
            DUR: begin
                if (sayac_q == UART_SAAT) begin
                    sayac_d = 32'd0;
                    if (rx_s_q) begin
                        teslim  = 1'b1;
                        durum_d = BOSTA;
                    end else begin
                        hata_d  = 1'b1;
                        durum_d = BEKLE;
                    end
                end else begin
                    sayac_d = sayac_q + 32'd1;
                end
            end
            BEKLE: begin
                // a held-low line (break) must not be decoded as a stream of 0x00 frames
                sayac_d = 32'd0;
                if (rx_s_q) durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
                sayac_d = 32'd0;
            end
        endcase

        if (teslim) begin
            if (!gecerli_q || al_hazir) begin
                veri_d    = kaydirma_q;
                gecerli_d = 1'b1;
            end else begin
                tasma_d = 1'b1;
            end
        end
    end

    assign al_veri      = veri_q;
    assign al_gecerli   = gecerli_q;
    assign cerceve_hata = hata_q;
    assign tasma        = tasma_q;
    assign mesgul       = (durum_q != BOSTA);

endmodule

// File: tb/tb_uart_alici.sv
// Bench for uart_alici: directed frames plus randomized frames checked against a
// frame-level model of what the consumer should see.
module tb_uart_alici;

    localparam int PER = 17;
    localparam int FRAME = 10 * PER;

    logic       clk_g = 1'b0;
    logic       rst_g;
    logic       RX;
    logic [7:0] al_veri;
    logic       al_gecerli;
    logic       al_hazir;
    logic       cerceve_hata;
    logic       tasma;
    logic       mesgul;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int gec_n = 0;
    int tasma_n = 0;
    int hata_n = 0;
    int busy_n = 0;
    int rise_cyc = 0;
    logic gec_prev = 1'b0;
    logic hz_lvl = 1'b0;
    int start_cyc = 0;
    logic [7:0] acc_q[$];

    uart_alici #(.UART_SAAT(32'd16)) dut (
        .clk_g       (clk_g),
        .rst_g       (rst_g),
        .RX          (RX),
        .al_veri     (al_veri),
        .al_gecerli  (al_gecerli),
        .al_hazir    (al_hazir),
        .cerceve_hata(cerceve_hata),
        .tasma       (tasma),
        .mesgul      (mesgul)
    );

    always #5 clk_g = ~clk_g;

    always @(posedge clk_g) cyc <= cyc + 1;

    always @(negedge clk_g) begin
        if (al_gecerli && al_hazir) acc_q.push_back(al_veri);
        if (al_gecerli) gec_n <= gec_n + 1;
        if (al_gecerli && !gec_prev) rise_cyc <= cyc;
        gec_prev <= al_gecerli;
        if (tasma) tasma_n <= tasma_n + 1;
        if (cerceve_hata) hata_n <= hata_n + 1;
        if (mesgul) busy_n <= busy_n + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_g);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drives ncyc cycles of a frame: start bit, 8 data bits LSB first, stop bit.
    // al_hazir follows hz_lvl except for a one-cycle high pulse at cycle hz_pulse.
    task automatic send(input logic [7:0] b, input logic stop, input int hz_pulse, input int ncyc);
        int bi;
        for (int c = 0; c < ncyc; c++) begin
            bi = c / PER;
            if (c == 0) start_cyc = cyc;
            if (bi == 0) RX = 1'b0;
            else if (bi <= 8) RX = b[bi-1];
            else RX = stop;
            al_hazir = (c == hz_pulse) ? 1'b1 : hz_lvl;
            tick(1);
        end
        al_hazir = hz_lvl;
    endtask

    initial begin
        int a0, g0, t0, h0, b0, lat, nbad, gap;
        logic [7:0] rb;
        logic good;
        logic [7:0] exp_q[$];

        rst_g = 1'b0;
        RX = 1'b1;
        al_hazir = 1'b0;
        tick(3);
        chk("rst_gecerli", {31'd0, al_gecerli}, 32'd0);
        chk("rst_veri", {24'd0, al_veri}, 32'd0);
        chk("rst_mesgul", {31'd0, mesgul}, 32'd0);
        chk("rst_pulses", {30'd0, tasma, cerceve_hata}, 32'd0);
        rst_g = 1'b1;
        tick(2);

        // single frame, consumer always ready
        hz_lvl = 1'b1;
        a0 = acc_q.size(); g0 = gec_n; t0 = tasma_n; h0 = hata_n;
        send(8'h5A, 1'b1, -1, FRAME);
        tick(4);
        chk("f5a_count", acc_q.size() - a0, 1);
        chk("f5a_byte", {24'd0, acc_q[acc_q.size()-1]}, 32'h5A);
        chk("f5a_valid_cycles", gec_n - g0, 1);
        chk("f5a_no_err", (tasma_n - t0) + (hata_n - h0), 0);
        chk("f5a_idle", {31'd0, mesgul}, 32'd0);
        // 2 sync + (16/2+1) start check + 9*17 bits + 1 delivery, +/-1
        lat = rise_cyc - start_cyc;
        chk("f5a_latency_in_window", {31'd0, (lat >= 164 && lat <= 166)}, 32'd1);

        // back-to-back frames with consumer stalled: second is an overrun
        hz_lvl = 1'b0;
        al_hazir = 1'b0;
        a0 = acc_q.size(); t0 = tasma_n; h0 = hata_n;
        send(8'h01, 1'b1, -1, FRAME);
        send(8'hFF, 1'b1, -1, FRAME);
        tick(4);
        chk("ovr_veri_held", {24'd0, al_veri}, 32'h01);
        chk("ovr_gecerli", {31'd0, al_gecerli}, 32'd1);
        chk("ovr_tasma_once", tasma_n - t0, 1);
        chk("ovr_no_ferr", hata_n - h0, 0);
        al_hazir = 1'b1;
        tick(1);
        al_hazir = 1'b0;
        tick(2);
        chk("ovr_accept_count", acc_q.size() - a0, 1);
        chk("ovr_accept_byte", {24'd0, acc_q[acc_q.size()-1]}, 32'h01);
        chk("ovr_gecerli_drop", {31'd0, al_gecerli}, 32'd0);

        // short glitch while idle
        g0 = gec_n; h0 = hata_n; b0 = busy_n;
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(20);
        chk("glitch_idle", {31'd0, mesgul}, 32'd0);
        chk("glitch_busy_bound", {31'd0, (busy_n - b0 >= 1 && busy_n - b0 <= 10)}, 32'd1);
        chk("glitch_no_valid", gec_n - g0, 0);
        chk("glitch_no_ferr", hata_n - h0, 0);

        // framing error, line held low (break), then a clean frame
        hz_lvl = 1'b1;
        a0 = acc_q.size(); g0 = gec_n; h0 = hata_n;
        send(8'hA5, 1'b0, -1, FRAME);
        RX = 1'b0;
        tick(60);
        chk("ferr_pulse_once", hata_n - h0, 1);
        chk("ferr_no_valid", gec_n - g0, 0);
        chk("ferr_wait_busy", {31'd0, mesgul}, 32'd1);
        RX = 1'b1;
        tick(6);
        chk("ferr_release_idle", {31'd0, mesgul}, 32'd0);
        send(8'h3C, 1'b1, -1, FRAME);
        tick(4);
        chk("ferr_next_count", acc_q.size() - a0, 1);
        chk("ferr_next_byte", {24'd0, acc_q[acc_q.size()-1]}, 32'h3C);

        // reset in the middle of data bit 4 with a byte pending
        hz_lvl = 1'b0;
        al_hazir = 1'b0;
        send(8'h96, 1'b1, -1, FRAME);
        tick(3);
        chk("rstm_pending", {23'd0, al_gecerli, al_veri}, {23'd0, 1'b1, 8'h96});
        send(8'hE7, 1'b1, -1, 5 * PER + 8);
        chk("rstm_busy_before", {31'd0, mesgul}, 32'd1);
        RX = 1'b1;
        rst_g = 1'b0;
        tick(1);
        rst_g = 1'b1;
        chk("rstm_outputs", {20'd0, al_veri, al_gecerli, tasma, cerceve_hata, mesgul}, 32'd0);
        a0 = acc_q.size(); g0 = gec_n;
        tick(30);
        chk("rstm_quiet", (gec_n - g0) + {31'd0, mesgul}, 0);
        hz_lvl = 1'b1;
        al_hazir = 1'b1;
        send(8'hC3, 1'b1, -1, FRAME);
        tick(4);
        chk("rstm_next_count", acc_q.size() - a0, 1);
        chk("rstm_next_byte", {24'd0, acc_q[acc_q.size()-1]}, 32'hC3);

        // accept and new byte on the same cycle
        hz_lvl = 1'b0;
        al_hazir = 1'b0;
        send(8'h11, 1'b1, -1, FRAME);
        tick(3);
        a0 = acc_q.size(); t0 = tasma_n;
        send(8'h77, 1'b1, 164, FRAME);
        tick(3);
        chk("b2b_no_tasma", tasma_n - t0, 0);
        chk("b2b_veri", {24'd0, al_veri}, 32'h77);
        chk("b2b_gecerli", {31'd0, al_gecerli}, 32'd1);
        chk("b2b_old_accepted", {24'd0, acc_q[acc_q.size()-1]}, 32'h11);
        al_hazir = 1'b1;
        tick(1);
        al_hazir = 1'b0;
        tick(2);
        chk("b2b_new_accepted", {24'd0, acc_q[acc_q.size()-1]}, 32'h77);
        chk("b2b_accept_count", acc_q.size() - a0, 2);

        // randomized frames, random stop errors and idle gaps, consumer always ready
        hz_lvl = 1'b1;
        al_hazir = 1'b1;
        a0 = acc_q.size(); h0 = hata_n; t0 = tasma_n;
        nbad = 0;
        for (int i = 0; i < 14; i++) begin
            rb = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send(rb, good, -1, FRAME);
            if (good) begin
                exp_q.push_back(rb);
                gap = $urandom_range(0, 15);
            end else begin
                nbad++;
                gap = 4 + $urandom_range(0, 15);
            end
            RX = 1'b1;
            tick(gap);
        end
        tick(5);
        chk("rnd_count", acc_q.size() - a0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (a0 + i < acc_q.size())
                chk("rnd_byte", {24'd0, acc_q[a0+i]}, {24'd0, exp_q[i]});
        end
        chk("rnd_ferr_count", hata_n - h0, nbad);
        chk("rnd_no_tasma", tasma_n - t0, 0);
        chk("rnd_idle", {31'd0, mesgul}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
